// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//   Shares one pipelined 32-bit floating-point adder among N_REQ requesters.
//   A round-robin arbiter grants at most one valid requester per clock and
//   registers its operands onto the adder inputs. A valid/tag shift register
//   of depth LAT+1 follows every operation through the adder, so that the
//   requester ID can be paired with add_sum when it emerges. Finished sums
//   land in a first-word-fall-through result FIFO. Issue is limited by a
//   credit count (in flight + queued < FIFO_DEPTH), so the adder, which cannot
//   stall, never pushes into a full FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester grant, one-hot or zero
//   req_a      packed operand A, requester i at [32*i+31:32*i]
//   req_b      packed operand B, same packing
//   add_a      registered operand A to the adder
//   add_b      registered operand B to the adder
//   add_sum    adder result, valid LAT edges after add_a/add_b change
//   res_valid  result FIFO head valid
//   res_ready  consumer accepts the head
//   res_data   head sum
//   res_id     head requester ID
//   busy       an operation is in flight or the FIFO holds a result
// ---------------------------------------------------------------------------
module fp_add_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int LAT        = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_sum,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // Wide enough for every tag stage plus a full FIFO.
    localparam int OUT_W = $clog2(LAT + FIFO_DEPTH + 2);

    // Number of set bits in the valid pipe.
    function automatic logic [OUT_W-1:0] popcount_f(input logic [LAT:0] v);
        logic [OUT_W-1:0] c;
        c = '0;
        for (int k = 0; k <= LAT; k++) begin
            c = c + OUT_W'(v[k]);
        end
        return c;
    endfunction

    // Advance an index by one, wrapping at lim.
    function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1'b1);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LAT:0]       vld_r;
    logic [ID_W-1:0]    tag_r [0:LAT];
    logic [31:0]        add_a_r;
    logic [31:0]        add_b_r;
    logic [ID_W-1:0]    rr_ptr_r;

    logic [31:0]        mem_data_r [0:FIFO_DEPTH-1];
    logic [ID_W-1:0]    mem_id_r   [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [OUT_W-1:0]   outstanding_s;
    logic               can_issue_s;
    logic [ID_W:0]      sum_s;
    logic [ID_W-1:0]    idx_s;
    logic               found_s;
    logic [ID_W-1:0]    win_s;
    logic [31:0]        win_a_s;
    logic [31:0]        win_b_s;
    logic [N_REQ-1:0]   grant_s;
    logic [ID_W-1:0]    next_ptr_s;
    logic               push_s;
    logic               pop_s;

    // Credit: a pop in this cycle frees its slot only from the next cycle on.
    assign outstanding_s = popcount_f(vld_r) + OUT_W'(count_r);
    assign can_issue_s   = (outstanding_s < OUT_W'(FIFO_DEPTH));

    // Round-robin search starting at rr_ptr_r; the first valid requester wins.
    always_comb begin
        sum_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        win_s   = '0;
        win_a_s = 32'h0000_0000;
        win_b_s = 32'h0000_0000;
        grant_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(k);
            if (sum_s >= (ID_W + 1)'(N_REQ)) begin
                sum_s = sum_s - (ID_W + 1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[ID_W-1:0];
            if (can_issue_s && !found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
                win_a_s = req_a[{idx_s, 5'b00000} +: 32];
                win_b_s = req_b[{idx_s, 5'b00000} +: 32];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant_s[win_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        if (win_s == ID_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_s + ID_W'(1'b1);
        end
    end

    // No grant is visible while the block is held in reset.
    assign req_ready = grant_s & {N_REQ{rst_n}};

    assign push_s = vld_r[LAT];
    assign pop_s  = (count_r != '0) && res_ready;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Issue register: winner's operands to the adder and RR pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_r  <= 32'h0000_0000;
            add_b_r  <= 32'h0000_0000;
            rr_ptr_r <= '0;
        end else if (found_s) begin
            add_a_r  <= win_a_s;
            add_b_r  <= win_b_s;
            rr_ptr_r <= next_ptr_s;
        end else begin
            add_a_r  <= add_a_r;
            add_b_r  <= add_b_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Valid/tag pipe: shifts every edge, mirroring the adder's fixed latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            vld_r <= {vld_r[LAT-1:0], found_s};
            if (found_s) begin
                tag_r[0] <= win_s;
            end else begin
                tag_r[0] <= tag_r[0];
            end
            for (int k = 1; k <= LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // FIFO storage: capture {add_sum, tag} while the pipe's last stage is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_data_r[k] <= 32'h0000_0000;
                mem_id_r[k]   <= '0;
            end
        end else if (push_s) begin
            mem_data_r[wr_ptr_r] <= add_sum;
            mem_id_r[wr_ptr_r]   <= tag_r[LAT];
        end else begin
            mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
            mem_id_r[wr_ptr_r]   <= mem_id_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= push_s ? ptr_inc_f(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? ptr_inc_f(rd_ptr_r) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven directly from registers)
    // ------------------------------------------------------------------
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign res_valid = (count_r != '0);
    assign res_data  = mem_data_r[rd_ptr_r];
    assign res_id    = mem_id_r[rd_ptr_r];
    assign busy      = (|vld_r) || (count_r != '0);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_add_arbiter
//   Directed bench for fp_add_arbiter. A LAT-edge delay model stands in for
//   the FP adder. Every cycle the bench predicts the grant, busy and
//   res_valid from its own round-robin pointer and a scoreboard queue of
//   accepted operations (each entry carries the cycle at which its result
//   must appear); popped results are compared against the queue head.
// ---------------------------------------------------------------------------
module tb_fp_add_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*32-1:0]  req_a;
    logic [N_REQ*32-1:0]  req_b;
    logic [31:0]          add_a;
    logic [31:0]          add_b;
    logic [31:0]          add_sum;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_data;
    logic [ID_W-1:0]      res_id;
    logic                 busy;

    logic [31:0] a_arr [N_REQ];
    logic [31:0] b_arr [N_REQ];

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        int              rdy;
    } exp_t;

    exp_t sb[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int accepts   = 0;
    int ptr_m     = 0;
    int last_gnt  = -1;

    fp_add_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
        end
    end

    // Reference adder behaviour: a zero operand returns the other one.
    // Stimulus always zeroes one operand; other pairs yield a fixed marker.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h0) return b;
        else if (b == 32'h0) return a;
        else return 32'hBAD0_BAD0;
    endfunction

    // Adder delay model: result valid LAT edges after add_a/add_b change.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fadd(add_a, add_b);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign add_sum = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: predict and compare just before the edge, then step to the
    // following negedge where the caller may change inputs.
    task automatic cycle();
        int win;
        logic [N_REQ-1:0] exp_rdy;
        logic exp_rv;
        exp_t e;
        win = -1;
        last_gnt = -1;
        #1;
        if (rst_n) begin
            exp_rdy = '0;
            if (sb.size() < DEPTH) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (win < 0 && req_valid[(ptr_m + k) % N_REQ]) win = (ptr_m + k) % N_REQ;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(sb.size() != 0));
            exp_rv = (sb.size() != 0) && (cyc >= sb[0].rdy);
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            if (res_valid && res_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_id", 32'(res_id), 32'(e.id));
            end
            if (win >= 0) begin
                e.id   = ID_W'(win);
                e.data = fadd(a_arr[win], b_arr[win]);
                e.rdy  = cyc + LAT + 2;
                sb.push_back(e);
                ptr_m    = (win + 1) % N_REQ;
                accepts++;
                last_gnt = win;
                if (sb.size() > DEPTH) chk("overflow", 32'(sb.size()), 32'(DEPTH));
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        // Granted requester presents a fresh operation next.
        if (win >= 0) begin
            if (a_arr[win] == 32'h0) b_arr[win] = b_arr[win] + 32'h1;
            else a_arr[win] = a_arr[win] + 32'h1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        req_valid = '0;
        res_ready = 1'b1;
        while (sb.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int acc0;
        int g [3];
        rst_n     = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = 32'h0;
            b_arr[i] = 32'h0;
        end

        // Reset state, with requests pending to prove req_ready is held low.
        #2 rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        req_valid = '0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // 1: single request from requester 2, latency to res_valid.
        a_arr[2] = 32'h0000_0000;
        b_arr[2] = 32'h4049_0FDB;
        req_valid = 4'b0100;
        cycle();
        chk("t1_grant", 32'(last_gnt), 32'd2);
        req_valid = '0;
        n = 1;
        while (res_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk("t1_latency", 32'(n), 32'd7);
        chk("t1_res_data", res_data, 32'h4049_0FDB);
        chk("t1_res_id", 32'(res_id), 32'd2);
        drain("t1_drain");

        // 2: all four requesting, consumer always ready.
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = 32'h0;
            b_arr[i] = {8'(i + 1), 24'h00_0000};
        end
        res_ready = 1'b1;
        req_valid = 4'hF;
        acc0 = accepts;
        repeat (24) cycle();
        chk("t2_issue_rate", 32'(accepts - acc0), 32'd24);
        drain("t2_drain");

        // 3: consumer stalled, requester 0 streams until credit runs out.
        res_ready = 1'b0;
        req_valid = 4'b0001;
        acc0 = accepts;
        repeat (20) cycle();
        chk("t3_accepts", 32'(accepts - acc0), 32'd8);
        chk("t3_ready_low", 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        cycle();
        chk("t3_no_issue_on_pop", 32'(accepts - acc0), 32'd8);
        cycle();
        chk("t3_ninth_issue", 32'(accepts - acc0), 32'd9);
        drain("t3_drain");

        // 4: FIFO holds 7 while the 8th result arrives; pop and push together.
        res_ready = 1'b0;
        req_valid = 4'b0001;
        acc0 = accepts;
        n = 0;
        while (accepts - acc0 < 8 && n < 30) begin
            cycle();
            n++;
        end
        chk("t4_accepts", 32'(accepts - acc0), 32'd8);
        req_valid = '0;
        n = 0;
        while (sb.size() == 8 && cyc < sb[7].rdy - 1 && n < 30) begin
            cycle();
            n++;
        end
        chk("t4_pre_rv", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        repeat (3) cycle();
        res_ready = 1'b1;
        repeat (7) cycle();
        chk("t4_empty_after_7", 32'(res_valid), 32'd0);
        drain("t4_drain");

        // 5: reset with 3 in flight and 2 queued.
        res_ready = 1'b0;
        req_valid = 4'b0001;
        acc0 = accepts;
        n = 0;
        while (accepts - acc0 < 5 && n < 20) begin
            cycle();
            n++;
        end
        req_valid = '0;
        n = 0;
        while (sb.size() == 5 && cyc < sb[1].rdy && n < 20) begin
            cycle();
            n++;
        end
        chk("t5_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        ptr_m = 0;
        req_valid = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (10) cycle();
        chk("t5_post_busy", 32'(busy), 32'd0);

        // 6: move pointer to 2, then requesters 1 and 3 contend (A path used).
        a_arr[1] = 32'h3F80_0000;
        b_arr[1] = 32'h0;
        req_valid = 4'b0010;
        cycle();
        chk("t6_setup_grant", 32'(last_gnt), 32'd1);
        drain("t6_setup_drain");
        a_arr[1] = 32'h4000_0000;
        a_arr[3] = 32'h4040_0000;
        b_arr[1] = 32'h0;
        b_arr[3] = 32'h0;
        res_ready = 1'b1;
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            g[k] = last_gnt;
        end
        chk("t6_grant0", 32'(g[0]), 32'd3);
        chk("t6_grant1", 32'(g[1]), 32'd1);
        chk("t6_grant2", 32'(g[2]), 32'd3);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
